hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// - Produces the control side of the pipeline-register interface: the stall, flush and forward selects
//   that gate every stage register, including clr of the D->E register.
// - Detects load-use hazards, squashes wrong-path work on taken branches and jumps, and selects EX-stage forwarding.
// - Freezes the whole pipeline while data memory is busy. Sits beside the datapath, fed by Decode/Execute/Memory/Writeback.
// PARAMETERS
// - CNT_W   32   width of performance counters (only with HAZARD_PERF_EN)
// PORTS
// - clk           in   1   clock, rising edge
// - rst           in   1   asynchronous reset, active-high
// - Rs1_D, Rs2_D  in   5   source regs of instruction in Decode
// - Rs1_E, Rs2_E  in   5   source regs of instruction in Execute
// - Rd_E          in   5   dest reg in Execute
// - ResultSrc_E   in   2   result select in Execute; RESULT_SRC_LOAD (2'b01) marks a load
// - Rd_M, Rd_W    in   5   dest regs in Memory / Writeback
// - RegWrite_M    in   1   Memory-stage instruction writes Rd_M
// - RegWrite_W    in   1   Writeback-stage instruction writes Rd_W
// - PCSrc_E       in   1   taken branch/jump; single-cycle pulse per control transfer
// - mem_busy_M    in   1   data memory not ready; pipeline must hold
// - Stall_F, Stall_D, Stall_E, Stall_M   out 1   hold PC / F->D / D->E / E->M registers
// - Flush_D       out  1   clear F->D register
// - Flush_E       out  1   clear D->E register (drives its clr)
// - ForwardA_E, ForwardB_E   out 2   operand source, fwd_sel_e
// - perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt   out CNT_W   only with HAZARD_PERF_EN
// BEHAVIOUR
// - Reset:
//   - State S_RUN, flush_pend=0.
//   - While rst is high: all Stall/Flush outputs 0, Forward outputs FWD_NONE, counters 0.
// - Forwarding (combinational, every state), per operand:
//   - FWD_M if RegWrite_M && Rd_M!=0 && Rd_M==Rs_E.
//   - Else FWD_W if RegWrite_W && Rd_W!=0 && Rd_W==Rs_E.
//   - Else FWD_NONE. M has priority over W.
// - lw_stall = ResultSrc_E==RESULT_SRC_LOAD && Rd_E!=0 && (Rd_E==Rs1_D || Rd_E==Rs2_D).
// - FSM states: S_RUN, S_FREEZE.
//   - S_RUN, mem_busy_M=0:
//     - PCSrc_E: Flush_D=Flush_E=1, no stall. Flush wins over a simultaneous lw_stall.
//     - Else lw_stall: Stall_F=Stall_D=1, Flush_E=1 (one bubble).
//     - Else all 0.
//   - S_RUN, mem_busy_M=1:
//     - Stall_F/D/E/M=1 in the same cycle; all flushes 0; go to S_FREEZE.
//     - flush_pend <= PCSrc_E.
//   - S_FREEZE, mem_busy_M=1:
//     - Stall_F/D/E/M=1; all flushes 0; lw_stall ignored.
//     - flush_pend <= flush_pend | PCSrc_E.
//   - S_FREEZE, mem_busy_M=0 (release cycle):
//     - Stalls 0. Go to S_RUN, flush_pend <= 0.
//     - If flush_pend | PCSrc_E: Flush_D=Flush_E=1.
//     - Else lw_stall is evaluated as in S_RUN.
// - A taken transfer is never lost and never flushes twice.
// - Reset mid-freeze: returns to S_RUN, pending flush discarded.
// CONFIGURATION
// - HAZARD_PERF_EN defined:
//   - Saturating counters increment once per cycle on lw_stall-stall, on a flush, and on a frozen cycle.
//   - Cleared only by rst.
// - HAZARD_PERF_EN undefined: perf ports and counters absent. All other behaviour identical.
// STRUCTURE
// - hazard_pkg: fwd_sel_e {FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10}; hz_state_e {S_RUN, S_FREEZE};
//   RESULT_SRC_LOAD. The same package is imported by the E-stage operand muxes.
// - Sub-module fwd_select: one operand's compare/priority logic, instanced twice (A, B).
// TESTING
// - Rd_M=5,RegWrite_M=1,Rd_W=5,RegWrite_W=1,Rs1_E=5 -> ForwardA_E=FWD_M; set Rd_M=0 -> FWD_W.
// - Rd_W=0,RegWrite_W=1,Rs2_E=0 -> ForwardB_E=FWD_NONE.
// - Load Rd_E=7, Rs2_D=7 -> one cycle Stall_F=Stall_D=Flush_E=1; next cycle (Rd_E changed) all 0.
// - Load-use and PCSrc_E=1 same cycle -> Flush_D=Flush_E=1, Stall_F=Stall_D=0.
// - mem_busy_M high 3 cycles, PCSrc_E pulse in 2nd -> 3 cycles all Stall=1, Flush=0; release cycle Flush_D=Flush_E=1 exactly once.
// - rst asserted mid-freeze with pending flush -> outputs 0 immediately; after release no flush.
// - HAZARD_PERF_EN: 2 load-use stalls, 1 flush, 3 frozen cycles -> counters 2/1/3.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard controller and the E-stage
// operand muxes.
//   fwd_sel_e       : operand source select (none / from W / from M)
//   hz_state_e      : hazard controller FSM states
//   RESULT_SRC_LOAD : ResultSrc encoding that marks a load instruction
//   reg_hit()       : "this writer produces the register being read" test
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_FREEZE = 1'b1
  } hz_state_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // x0 is hardwired to zero, so a write to it never produces a value.
  function automatic logic reg_hit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// fwd_select: forwarding select for one Execute-stage source operand.
// Ports:
//   rs           in  5  source register read in Execute
//   rd_m         in  5  Memory-stage destination register
//   reg_write_m  in  1  Memory-stage instruction writes rd_m
//   rd_w         in  5  Writeback-stage destination register
//   reg_write_w  in  1  Writeback-stage instruction writes rd_w
//   fwd          out 2  operand source (fwd_sel_e)
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // The M-stage result is younger than W, so it must win.
  always_comb begin
    fwd = FWD_NONE;
    if (reg_hit(reg_write_m, rd_m, rs)) begin
      fwd = FWD_M;
    end else if (reg_hit(reg_write_w, rd_w, rs)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit. Produces stall, flush and forwarding
// selects for the stage registers: load-use bubble insertion, wrong-path
// squash on taken transfers, EX forwarding, and a full-pipeline freeze while
// data memory is busy. A transfer taken during a freeze is remembered and
// applied exactly once in the release cycle.
// Optional feature macro: HAZARD_PERF_EN adds saturating performance counters.
// Ports:
//   clk, rst                    clock (rising) / async active-high reset
//   Rs1_D, Rs2_D                Decode source registers
//   Rs1_E, Rs2_E, Rd_E          Execute source / destination registers
//   ResultSrc_E                 Execute result select (load marker)
//   Rd_M, RegWrite_M            Memory destination / write enable
//   Rd_W, RegWrite_W            Writeback destination / write enable
//   PCSrc_E                     taken branch/jump pulse
//   mem_busy_M                  data memory not ready
//   Stall_F/D/E/M               hold PC / F->D / D->E / E->M registers
//   Flush_D, Flush_E            clear F->D / D->E registers
//   ForwardA_E, ForwardB_E      operand source selects
//   perf_*_cnt                  stall / flush / freeze counters (HAZARD_PERF_EN)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [1:0]       ResultSrc_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             PCSrc_E,
  input  logic             mem_busy_M,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_freeze_cnt
`endif
);

  // ---------------------------------------------------------------------
  // Forwarding: one selector per operand (0 = A/Rs1, 1 = B/Rs2)
  // ---------------------------------------------------------------------
  logic [4:0] rs_e    [2];
  logic [1:0] fwd_raw [2];

  assign rs_e[0] = Rs1_E;
  assign rs_e[1] = Rs2_E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_select u_fwd (
      .rs          (rs_e[gi]),
      .rd_m        (Rd_M),
      .reg_write_m (RegWrite_M),
      .rd_w        (Rd_W),
      .reg_write_w (RegWrite_W),
      .fwd         (fwd_raw[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Stall / flush FSM
  // ---------------------------------------------------------------------
  hz_state_e state_reg, state_next;
  logic      flush_pend_reg, flush_pend_next;

  logic lw_stall;
  logic stall_f_c, stall_d_c, stall_e_c, stall_m_c;
  logic flush_d_c, flush_e_c;

  assign lw_stall = (ResultSrc_E == RESULT_SRC_LOAD) && (Rd_E != 5'd0) &&
                    ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  always_comb begin
    state_next      = state_reg;
    flush_pend_next = flush_pend_reg;
    stall_f_c       = 1'b0;
    stall_d_c       = 1'b0;
    stall_e_c       = 1'b0;
    stall_m_c       = 1'b0;
    flush_d_c       = 1'b0;
    flush_e_c       = 1'b0;

    if (mem_busy_M) begin
      // Frozen: everything holds, nothing is cleared; a transfer seen now
      // is deferred to the release cycle so it is neither lost nor doubled.
      stall_f_c  = 1'b1;
      stall_d_c  = 1'b1;
      stall_e_c  = 1'b1;
      stall_m_c  = 1'b1;
      state_next = S_FREEZE;
      if (state_reg == S_RUN) begin
        flush_pend_next = PCSrc_E;
      end else begin
        flush_pend_next = flush_pend_reg | PCSrc_E;
      end
    end else begin
      // Running or release cycle. flush_pend_reg is only ever set while
      // frozen, so in S_RUN it contributes nothing.
      state_next      = S_RUN;
      flush_pend_next = 1'b0;
      if (PCSrc_E || ((state_reg == S_FREEZE) && flush_pend_reg)) begin
        // Squash wins over a load-use bubble: the dependent instruction is
        // on the wrong path anyway.
        flush_d_c = 1'b1;
        flush_e_c = 1'b1;
      end else if (lw_stall) begin
        stall_f_c = 1'b1;
        stall_d_c = 1'b1;
        flush_e_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_RUN;
      flush_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

  // Outputs are forced inactive for the whole reset interval, not just
  // after the next edge.
  assign Stall_F    = stall_f_c & ~rst;
  assign Stall_D    = stall_d_c & ~rst;
  assign Stall_E    = stall_e_c & ~rst;
  assign Stall_M    = stall_m_c & ~rst;
  assign Flush_D    = flush_d_c & ~rst;
  assign Flush_E    = flush_e_c & ~rst;
  assign ForwardA_E = rst ? FWD_NONE : fwd_raw[0];
  assign ForwardB_E = rst ? FWD_NONE : fwd_raw[1];

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------
  logic             evt [3];
  logic [CNT_W-1:0] cnt_reg [3];

  // A load-use stall is the only case with stall_d but not stall_m.
  assign evt[0] = stall_d_c & ~stall_m_c;
  assign evt[1] = flush_d_c;
  assign evt[2] = stall_m_c;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg[gi] <= '0;
      end else if (evt[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign perf_stall_cnt  = cnt_reg[0];
  assign perf_flush_cnt  = cnt_reg[1];
  assign perf_freeze_cnt = cnt_reg[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. The stimulus process
// applies one input vector per cycle, predicts the response from a
// behavioural model of the hazard rules and queues it; the monitor pops and
// compares on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0] ResultSrc_E;
  logic       RegWrite_M, RegWrite_W, PCSrc_E, mem_busy_M;
  logic       Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
  logic [1:0] ForwardA_E, ForwardB_E;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .ResultSrc_E(ResultSrc_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .PCSrc_E(PCSrc_E), .mem_busy_M(mem_busy_M),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_freeze_cnt(perf_freeze_cnt)
`endif
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] res_src;
    logic       rw_m, rw_w, pcsrc, busy;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        sf, sd, se, sm, fd, fe;
    logic [1:0]  fa, fb;
    int unsigned c_st, c_fl, c_fr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Model state: "is the memory currently holding us" and "a transfer was
  // seen while held and still owes its squash".
  bit          m_frozen  = 0;
  bit          m_pending = 0;
  int unsigned n_st = 0, n_fl = 0, n_fr = 0;

  task automatic chk(input string name, input int c, input longint act,
                     input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, req);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] rs, input stim_t s);
    if (s.rw_m && s.rd_m != 0 && s.rd_m == rs) return 2'b10;
    if (s.rw_w && s.rd_w != 0 && s.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   load_use;
    @(posedge clk);
    #1;
    rst = s.rst; Rs1_D = s.rs1_d; Rs2_D = s.rs2_d; Rs1_E = s.rs1_e;
    Rs2_E = s.rs2_e; Rd_E = s.rd_e; Rd_M = s.rd_m; Rd_W = s.rd_w;
    ResultSrc_E = s.res_src; RegWrite_M = s.rw_m; RegWrite_W = s.rw_w;
    PCSrc_E = s.pcsrc; mem_busy_M = s.busy;

    e = '{default: '0};
    e.cyc = cyc;
    if (s.rst) begin
      m_frozen = 0; m_pending = 0; n_st = 0; n_fl = 0; n_fr = 0;
    end
    e.c_st = n_st; e.c_fl = n_fl; e.c_fr = n_fr;
    if (!s.rst) begin
      e.fa = fwd_of(s.rs1_e, s);
      e.fb = fwd_of(s.rs2_e, s);
      load_use = (s.res_src == 2'b01) && (s.rd_e != 0) &&
                 (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
      if (s.busy) begin
        {e.sf, e.sd, e.se, e.sm} = 4'b1111;
        m_pending = m_pending | s.pcsrc;
        m_frozen  = 1;
        n_fr++;
      end else begin
        if (s.pcsrc || m_pending) begin
          e.fd = 1; e.fe = 1; n_fl++;
        end else if (load_use) begin
          e.sf = 1; e.sd = 1; e.fe = 1; n_st++;
        end
        m_frozen = 0; m_pending = 0;
      end
    end
    q.push_back(e);
    cyc++;
  endtask

  // Monitor: compare every output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_f", e.cyc, Stall_F, e.sf);
        chk("stall_d", e.cyc, Stall_D, e.sd);
        chk("stall_e", e.cyc, Stall_E, e.se);
        chk("stall_m", e.cyc, Stall_M, e.sm);
        chk("flush_d", e.cyc, Flush_D, e.fd);
        chk("flush_e", e.cyc, Flush_E, e.fe);
        chk("fwd_a",   e.cyc, ForwardA_E, e.fa);
        chk("fwd_b",   e.cyc, ForwardB_E, e.fb);
`ifdef HAZARD_PERF_EN
        chk("perf_stall",  e.cyc, perf_stall_cnt,  e.c_st);
        chk("perf_flush",  e.cyc, perf_flush_cnt,  e.c_fl);
        chk("perf_freeze", e.cyc, perf_freeze_cnt, e.c_fr);
`endif
      end
    end
  end

  initial begin
    stim_t s;
    bit    prev_pc;
    int    busy_left;

    rst = 1'b1;
    s = idle(); s.rst = 1;
    step(s); step(s);

    // Perf scenario first so counters start from reset: 2 load-use stalls,
    // 1 flush, 3 frozen cycles.
    s = idle(); s.res_src = 2'b01; s.rd_e = 7; s.rs2_d = 7; step(s);
    s = idle(); s.res_src = 2'b01; s.rd_e = 3; s.rs2_d = 7; step(s);
    s = idle(); s.res_src = 2'b01; s.rd_e = 9; s.rs1_d = 9; step(s);
    s = idle(); s.pcsrc = 1; step(s);
    s = idle(); s.busy = 1; step(s); step(s); step(s);
    s = idle(); step(s);
    step(s);
`ifdef HAZARD_PERF_EN
    @(negedge clk); #1;
    chk("perf_directed_stall",  cyc, perf_stall_cnt,  2);
    chk("perf_directed_flush",  cyc, perf_flush_cnt,  1);
    chk("perf_directed_freeze", cyc, perf_freeze_cnt, 3);
`endif

    // Forwarding priority and x0.
    s = idle(); s.rd_m = 5; s.rw_m = 1; s.rd_w = 5; s.rw_w = 1; s.rs1_e = 5; step(s);
    s.rd_m = 0; step(s);
    s = idle(); s.rd_w = 0; s.rw_w = 1; s.rs2_e = 0; step(s);

    // Load-use coinciding with a taken transfer.
    s = idle(); s.res_src = 2'b01; s.rd_e = 7; s.rs2_d = 7; s.pcsrc = 1; step(s);
    s = idle(); step(s);

    // Freeze with transfer in the 2nd busy cycle, then release.
    s = idle(); s.busy = 1; step(s);
    s.pcsrc = 1; step(s);
    s.pcsrc = 0; step(s);
    s = idle(); step(s);
    step(s);

    // Reset mid-freeze with a pending flush.
    s = idle(); s.busy = 1; step(s);
    s.pcsrc = 1; step(s);
    s.pcsrc = 0; s.rst = 1; step(s);
    s = idle(); step(s);
    step(s);

    // Randomized traffic.
    prev_pc = 0; busy_left = 0;
    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(0, 299) == 0);
      s.rs1_d   = 5'($urandom_range(0, 7));
      s.rs2_d   = 5'($urandom_range(0, 7));
      s.rs1_e   = 5'($urandom_range(0, 7));
      s.rs2_e   = 5'($urandom_range(0, 7));
      s.rd_e    = 5'($urandom_range(0, 7));
      s.rd_m    = 5'($urandom_range(0, 7));
      s.rd_w    = 5'($urandom_range(0, 7));
      s.res_src = 2'($urandom_range(0, 3));
      s.rw_m    = 1'($urandom_range(0, 1));
      s.rw_w    = 1'($urandom_range(0, 1));
      s.pcsrc   = prev_pc ? 1'b0 : ($urandom_range(0, 5) == 0);
      if (busy_left == 0 && $urandom_range(0, 7) == 0)
        busy_left = $urandom_range(1, 4);
      s.busy    = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      prev_pc = s.pcsrc;
      step(s);
    end

    s = idle(); step(s);
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
